cga_bus_if: RTL and testbench

//  Parametrised ISA-side register/bus front end for the CGA-class adapter. It decodes the mode,

---
 rtl/cga_bus_if.sv | 137 +++++++++++++
 tb/tb_cga_bus_if.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cga_bus_if.sv
// cga_bus_if: ISA port decode, register file, strobe/status sync, VRAM wait FSM and blink for the CGA adapter
module cga_bus_if #(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
    parameter int          USE_BUS_WAIT = 0,
    parameter logic [4:0]  SLOT_START   = 5'd17,
    parameter logic [4:0]  SLOT_END     = 5'd20,
    parameter int          BLINK_FRAMES = 8,
    parameter logic [7:0]  CTRL_RESET   = 8'h28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    input  logic        mem_cs,
    input  logic [4:0]  clk_seq,
    input  logic [7:0]  crtc_dout,
    input  logic        vsync_l,
    input  logic        display_en,
    input  logic        lp_sw_l,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy,
    output logic        crtc_cs,
    output logic        crtc_wr,
    output logic [7:0]  ctrl_reg,
    output logic [7:0]  color_reg,
    output logic        blink
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_OPEN, S_WAIT_DONE, S_READY} state_t;

    logic       r_iow_s1, r_iow_s2, r_iow_s3, r_armed;
    logic [1:0] r_live;
    logic       r_vs_s1, r_vs_s2, r_vs_s3, r_de_s1, r_de_s2;
    logic [7:0] r_ctrl, r_color, r_cnt;
    logic       r_lp, r_blink, r_rdy;
    state_t     r_state;

    logic       w_hit, w_crtc, w_wr_stb, w_stat_sel, w_crtc_rd, w_access, w_vs_rise;
    logic [7:0] w_status;

    assign w_hit      = ~bus_aen & (bus_a[15:4] == IO_BASE_ADDR[15:4]);
    assign w_crtc     = w_hit & ~bus_a[3];
    // Strobes only after a released (high) iow_l has been seen, so a write spanning reset is dropped
    assign w_wr_stb   = r_armed & r_iow_s3 & ~r_iow_s2;
    assign w_stat_sel = w_hit & (bus_a[3:0] == 4'hA);
    assign w_crtc_rd  = w_crtc & bus_a[0];
    assign w_access   = mem_cs & (~bus_memr_l | ~bus_memw_l);
    assign w_vs_rise  = r_vs_s3 & ~r_vs_s2;
    assign w_status   = {4'b1111, r_vs_s2, lp_sw_l, r_lp, ~r_de_s2};

    assign crtc_cs   = w_crtc;
    assign crtc_wr   = w_wr_stb & w_crtc;
    assign bus_dir   = ~bus_ior_l & (w_stat_sel | w_crtc_rd);
    assign bus_out   = (~bus_ior_l & w_stat_sel) ? w_status :
                       (~bus_ior_l & w_crtc_rd)  ? crtc_dout : 8'h00;
    assign bus_rdy   = (USE_BUS_WAIT != 0) ? r_rdy : 1'b1;
    assign ctrl_reg  = r_ctrl;
    assign color_reg = r_color;
    assign blink     = r_blink;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iow_s1 <= 1'b1;
            r_iow_s2 <= 1'b1;
            r_iow_s3 <= 1'b1;
            r_live   <= 2'b00;
            r_armed  <= 1'b0;
            r_vs_s1  <= 1'b1;
            r_vs_s2  <= 1'b1;
            r_vs_s3  <= 1'b1;
            r_de_s1  <= 1'b0;
            r_de_s2  <= 1'b0;
        end else begin
            r_iow_s1 <= bus_iow_l;
            r_iow_s2 <= r_iow_s1;
            r_iow_s3 <= r_iow_s2;
            r_live   <= {r_live[0], 1'b1};
            r_armed  <= r_armed | (r_live[1] & r_iow_s2);
            r_vs_s1  <= vsync_l;
            r_vs_s2  <= r_vs_s1;
            r_vs_s3  <= r_vs_s2;
            r_de_s1  <= display_en;
            r_de_s2  <= r_de_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl  <= CTRL_RESET;
            r_color <= 8'h00;
            r_lp    <= 1'b0;
        end else if (w_wr_stb && w_hit) begin
            if (bus_a[3:0] == 4'h8) r_ctrl <= bus_d;
            if (bus_a[3:0] == 4'h9) r_color <= bus_d;
            if (bus_a[3:0] == 4'hB) r_lp <= 1'b0;
            if (bus_a[3:0] == 4'hC) r_lp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 8'd0;
            r_blink <= 1'b0;
        end else if (w_vs_rise) begin
            r_cnt   <= (r_cnt == 8'(BLINK_FRAMES - 1)) ? 8'd0 : r_cnt + 8'd1;
            r_blink <= (r_cnt == 8'(BLINK_FRAMES - 1)) ? ~r_blink : r_blink;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b1;
        end else if (!w_access) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rdy   <= 1'b0;
                    r_state <= (clk_seq == SLOT_START) ? S_WAIT_DONE : S_WAIT_OPEN;
                end
                S_WAIT_OPEN: r_state <= (clk_seq == SLOT_START) ? S_WAIT_DONE : S_WAIT_OPEN;
                S_WAIT_DONE: begin
                    r_state <= (clk_seq == SLOT_END) ? S_READY : S_WAIT_DONE;
                    r_rdy   <= (clk_seq == SLOT_END);
                end
                default: r_rdy <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_cga_bus_if.sv
// tb_cga_bus_if: directed checks of decode, registers, status, wait FSM and blink
module tb_cga_bus_if;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen, mem_cs;
    logic [4:0]  clk_seq;
    logic [7:0]  crtc_dout;
    logic        vsync_l, display_en, lp_sw_l;
    logic [7:0]  bus_out, ctrl_reg, color_reg;
    logic        bus_dir, bus_rdy, crtc_cs, crtc_wr, blink;

    int n_checks = 0;
    int n_err = 0;
    int pulses;
    logic [7:0] rd;
    logic       dir;

    cga_bus_if #(.USE_BUS_WAIT(1), .BLINK_FRAMES(4)) dut (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_d(bus_d),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_aen(bus_aen), .mem_cs(mem_cs), .clk_seq(clk_seq),
        .crtc_dout(crtc_dout), .vsync_l(vsync_l), .display_en(display_en), .lp_sw_l(lp_sw_l),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy), .crtc_cs(crtc_cs),
        .crtc_wr(crtc_wr), .ctrl_reg(ctrl_reg), .color_reg(color_reg), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input int hold, output int p);
        bus_a = a;
        bus_d = d;
        bus_iow_l = 1'b0;
        p = 0;
        repeat (hold) begin
            tick();
            if (crtc_wr) p++;
        end
        bus_iow_l = 1'b1;
        repeat (4) begin
            tick();
            if (crtc_wr) p++;
        end
    endtask

    task automatic io_rd(input logic [15:0] a, output logic [7:0] d, output logic dr);
        bus_a = a;
        bus_ior_l = 1'b0;
        #1;
        d = bus_out;
        dr = bus_dir;
        bus_ior_l = 1'b1;
        #1;
    endtask

    task automatic vpulse();
        vsync_l = 1'b0;
        repeat (3) tick();
        vsync_l = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; bus_a = 16'h0; bus_d = 8'h0;
        bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
        bus_aen = 1'b0; mem_cs = 1'b0; clk_seq = 5'd0; crtc_dout = 8'hA5;
        vsync_l = 1'b1; display_en = 1'b0; lp_sw_l = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();

        chk("reset ctrl", ctrl_reg, 8'h28);
        chk("reset color", color_reg, 8'h00);
        chk("reset rdy", 8'(bus_rdy), 8'd1);
        chk("reset blink", 8'(blink), 8'd0);
        io_rd(16'h3D8, rd, dir);
        chk("read ctrl data", rd, 8'h00);
        chk("read ctrl dir", 8'(dir), 8'd0);

        io_wr(16'h3D8, 8'h1A, 4, pulses);
        chk("ctrl write no crtc_wr", 8'(pulses), 8'd0);
        io_wr(16'h3D9, 8'h05, 4, pulses);
        chk("ctrl written", ctrl_reg, 8'h1A);
        chk("color written", color_reg, 8'h05);
        bus_aen = 1'b1;
        io_wr(16'h3D8, 8'hFF, 4, pulses);
        io_wr(16'h3D9, 8'hFF, 4, pulses);
        bus_aen = 1'b0;
        chk("ctrl aen blocked", ctrl_reg, 8'h1A);
        chk("color aen blocked", color_reg, 8'h05);

        io_wr(16'h3D4, 8'h0E, 50, pulses);
        chk("held iow one crtc_wr", 8'(pulses), 8'd1);
        chk("crtc_cs at 3D4", 8'(crtc_cs), 8'd1);
        io_rd(16'h3D5, rd, dir);
        chk("read 3D5 data", rd, 8'hA5);
        chk("read 3D5 dir", 8'(dir), 8'd1);
        io_rd(16'h3D4, rd, dir);
        chk("read 3D4 data", rd, 8'h00);
        chk("read 3D4 dir", 8'(dir), 8'd0);
        bus_a = 16'h3D8; #1;
        chk("crtc_cs at 3D8", 8'(crtc_cs), 8'd0);
        bus_aen = 1'b1;
        bus_a = 16'h3D4; #1;
        chk("crtc_cs aen", 8'(crtc_cs), 8'd0);
        io_rd(16'h3D5, rd, dir);
        chk("read aen dir", 8'(dir), 8'd0);
        bus_aen = 1'b0;

        vsync_l = 1'b0; display_en = 1'b1; lp_sw_l = 1'b1;
        repeat (3) tick();
        io_wr(16'h3DC, 8'h00, 4, pulses);
        io_rd(16'h3DA, rd, dir);
        chk("status lp set", rd, 8'hF6);
        chk("status dir", 8'(dir), 8'd1);
        io_wr(16'h3DB, 8'h00, 4, pulses);
        io_rd(16'h3DA, rd, dir);
        chk("status lp clear", rd, 8'hF4);
        lp_sw_l = 1'b0; vsync_l = 1'b1; display_en = 1'b0;
        repeat (3) tick();
        io_rd(16'h3DA, rd, dir);
        chk("status idle", rd, 8'hF9);
        lp_sw_l = 1'b1;

        mem_cs = 1'b1; bus_memr_l = 1'b0;
        for (int v = 3; v <= 20; v++) begin
            clk_seq = 5'(v);
            if (v == 3 || v == 10 || v == 17 || v == 20) chk("wait rdy before edge", 8'(bus_rdy), (v == 3) ? 8'd1 : 8'd0);
            tick();
        end
        chk("rdy after slot end", 8'(bus_rdy), 8'd1);
        clk_seq = 5'd21; tick();
        chk("rdy held ready", 8'(bus_rdy), 8'd1);
        bus_memr_l = 1'b1; tick();
        chk("rdy idle", 8'(bus_rdy), 8'd1);

        clk_seq = 5'd17; bus_memw_l = 1'b0; tick();
        chk("direct done rdy low", 8'(bus_rdy), 8'd0);
        clk_seq = 5'd18; tick();
        clk_seq = 5'd19; tick();
        chk("direct done still low", 8'(bus_rdy), 8'd0);
        clk_seq = 5'd20; tick();
        chk("direct done rdy high", 8'(bus_rdy), 8'd1);
        bus_memw_l = 1'b1; tick();

        clk_seq = 5'd5; bus_memr_l = 1'b0; tick();
        chk("abort rdy low", 8'(bus_rdy), 8'd0);
        clk_seq = 5'd6; bus_memr_l = 1'b1; tick();
        chk("abort rdy high", 8'(bus_rdy), 8'd1);
        mem_cs = 1'b0; bus_memr_l = 1'b0; clk_seq = 5'd7; tick();
        chk("no mem_cs no wait", 8'(bus_rdy), 8'd1);
        mem_cs = 1'b1; clk_seq = 5'd3; tick();
        chk("pre-reset rdy low", 8'(bus_rdy), 8'd0);
        reset = 1'b1; tick();
        chk("mid-access reset rdy", 8'(bus_rdy), 8'd1);
        bus_memr_l = 1'b1; mem_cs = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("reset restores ctrl", ctrl_reg, 8'h28);

        for (int n = 1; n <= 8; n++) begin
            vpulse();
            chk("blink count", 8'(blink), ((n / 4) % 2 == 1) ? 8'd1 : 8'd0);
        end
        repeat (6) vpulse();
        chk("blink before reset", 8'(blink), 8'd1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("blink reset", 8'(blink), 8'd0);
        repeat (2) vpulse();
        chk("count cleared", 8'(blink), 8'd0);
        repeat (2) vpulse();
        chk("toggle after reset", 8'(blink), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
